inst_loader: RTL and testbench

- Writer side of the instruction-fetch path: receives a program image as a byte stream and writes 32-bit words into the instruction memory write port.
- Holds the core, i.e. keeps PC advance disabled, until a complete, checksum-verified image is resident.
- Sits between the byte source (UART receiver or test harness) and inst_mem. Its core_hold output gates the pc_reg enable.

---
 rtl/inst_loader_pkg.sv | 11 +
 rtl/inst_loader_byte_packer.sv | 27 ++
 rtl/inst_loader.sv | 108 ++++++++++
 tb/tb_inst_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared state encodings and constants for the image loader
package inst_loader_pkg;
    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int INST_W = 32;
endpackage

// File: rtl/inst_loader_byte_packer.sv
// byte_packer: little-endian 4-byte word assembler, word_valid marks the completing byte
module byte_packer
    import inst_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              word_valid,
    output logic [INST_W-1:0] word
);
    logic [1:0]  idx;
    logic [23:0] low;
    assign word_valid = in_valid && idx == 2'd3;
    assign word       = {in_data, low};
    // shift earlier bytes down so the first byte ends up in word[7:0]
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= 2'd0;
            low <= 24'd0;
        end else if (in_valid) begin
            idx <= idx + 2'd1;
            low <= {in_data, low[23:8]};
        end
    end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: receives a framed program image and writes it into instruction memory
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int         DEPTH     = 256,
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);
    logic [2:0]        state;
    logic [7:0]        len_lo;
    logic [15:0]       n;
    logic [15:0]       wcnt;
    logic [7:0]        csum;
    logic              acc;
    logic              restart;
    logic              word_valid;
    logic [INST_W-1:0] word;

    assign rx_ready  = state != S_DONE;
    assign acc       = rx_valid && rx_ready;
    assign restart   = state == S_DONE && reload;
    assign load_done = state == S_DONE;
    assign core_hold = !(state == S_DONE && !load_err);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart),
        .in_valid   (acc && state == S_DATA),
        .in_data    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // frame parser, checksum, word counter and the registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_SYNC;
            len_lo     <= 8'd0;
            n          <= 16'd0;
            wcnt       <= 16'd0;
            csum       <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (restart) begin
                state    <= S_SYNC;
                n        <= 16'd0;
                wcnt     <= 16'd0;
                csum     <= 8'd0;
                load_err <= 1'b0;
            end else if (acc) begin
                case (state)
                    S_SYNC: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= S_LEN0;
                            wcnt  <= 16'd0;
                            csum  <= 8'd0;
                        end
                    end
                    S_LEN0: begin
                        len_lo <= rx_data;
                        state  <= S_LEN1;
                    end
                    S_LEN1: begin
                        n     <= {rx_data, len_lo};
                        state <= ({rx_data, len_lo} != 16'd0) ? S_DATA : S_CSUM;
                    end
                    S_DATA: begin
                        csum <= csum ^ rx_data;
                        if (word_valid) begin
                            if (32'(wcnt) < DEPTH) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= wcnt[ADDR_W-1:0];
                                imem_wdata <= word;
                            end else begin
                                load_err <= 1'b1;
                            end
                            wcnt <= wcnt + 16'd1;
                            if (wcnt == n - 16'd1) state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (rx_data != csum) load_err <= 1'b1;
                        state <= S_DONE;
                    end
                    default: state <= S_SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed frames with a write scoreboard for inst_loader
module tb_inst_loader;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              load_done;
    logic              load_err;

    always #5 clk = ~clk;

    inst_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] words[$];
    int          checks   = 0;
    int          failures = 0;
    int          nstep    = 0;
    bit          gaps     = 1'b0;
    bit          pend     = 1'b0;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock; any write seen must match the oldest expected write, in its cycle
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        nstep++;
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_we_addr", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("we_cycle", 32'(nstep), 32'(e.due));
                chk("we_addr", 32'(imem_addr), e.addr);
                chk("we_data", imem_wdata, e.data);
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d);
        wr_t e;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                tick();
            end
        end
        if (pend && v) begin
            e.due  = nstep + 1;
            e.addr = pend_addr;
            e.data = pend_data;
            sb.push_back(e);
            pend = 1'b0;
        end
        rx_valid = v;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] n, input bit bad);
        logic [7:0]  csum;
        logic [7:0]  by;
        logic [31:0] w;
        csum = 8'h00;
        step(1'b1, 8'hA5);
        step(1'b1, n[7:0]);
        step(1'b1, n[15:8]);
        for (int k = 0; k < int'(n); k++) begin
            w = words[k];
            for (int b = 0; b < 4; b++) begin
                by   = w[8*b +: 8];
                csum = csum ^ by;
                if (b == 3 && k < DEPTH) begin
                    pend      = 1'b1;
                    pend_addr = 32'(k);
                    pend_data = w;
                end
                step(1'b1, by);
            end
        end
        if (int'(n) > DEPTH) chk("err_before_csum", 32'(load_err), 32'd1);
        step(1'b1, bad ? (csum ^ 8'h01) : csum);
    endtask

    task automatic check_done(input bit exp_err);
        chk("load_done", 32'(load_done), 32'd1);
        chk("load_err", 32'(load_err), 32'(exp_err));
        chk("core_hold", 32'(core_hold), 32'(exp_err));
        chk("rx_ready_done", 32'(rx_ready), 32'd0);
        chk("writes_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_done", 32'(load_done), 32'd0);
        chk("reload_err", 32'(load_err), 32'd0);
        chk("reload_hold", 32'(core_hold), 32'd1);
        chk("reload_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        tick();
        rst = 1'b0;
        sb.delete();
        pend = 1'b0;
        chk("rst_ready", 32'(rx_ready), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold", 32'(core_hold), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
    endtask

    // directed sequence: normal, garbage, bad checksum, zero length, overlength, mid-frame reset
    initial begin
        rst      = 1'b1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        do_reset();

        words = '{32'h0000_0013, 32'h0010_0093};
        send_frame(16'd2, 1'b0);
        check_done(1'b0);

        step(1'b1, 8'hA5);
        chk("done_ignores_bytes", 32'(load_done), 32'd1);

        do_reload();
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h5A);
        send_frame(16'd2, 1'b0);
        check_done(1'b0);

        do_reload();
        send_frame(16'd2, 1'b1);
        check_done(1'b1);
        do_reload();
        send_frame(16'd2, 1'b0);
        check_done(1'b0);

        do_reload();
        send_frame(16'd0, 1'b0);
        check_done(1'b0);

        do_reload();
        words = '{32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111, 32'h1111_1111};
        send_frame(16'd5, 1'b0);
        check_done(1'b1);

        do_reload();
        step(1'b1, 8'hA5);
        step(1'b1, 8'h02);
        step(1'b1, 8'h00);
        step(1'b1, 8'hEF);
        step(1'b1, 8'hBE);
        step(1'b1, 8'hAD);
        do_reset();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_outside_done", 32'(rx_ready), 32'd1);
        gaps  = 1'b1;
        words = '{32'hDEAD_BEEF, 32'h1234_5678};
        send_frame(16'd2, 1'b0);
        check_done(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
